// File: rtl/result_wb_pkg.sv
// Shared types and helpers for the result writeback stage: FSM state encoding
// and the packing of the {rows, cols} dimension header word.
package result_wb_pkg;

    localparam int WB_DIM_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } e_wb_state;

    // Rows occupy the upper half of the header word, columns the lower half.
    function automatic logic [2*WB_DIM_W-1:0] pack_dim_header(
        input logic [WB_DIM_W-1:0] rows,
        input logic [WB_DIM_W-1:0] cols
    );
        return {rows, cols};
    endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Small synchronous element buffer between the upstream handshake and the SRAM
// write port. Power-of-two depth so the pointers wrap naturally.
module result_fifo
    import result_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/result_writeback.sv
// Result writeback: buffers finished matrix elements and writes them row-major
// into the result SRAM. Define RESULT_HEADER_EN to emit a {rows,cols} header first.
module result_writeback
    import result_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  dut__tb__sram_result_write_enable,
    output logic [ADDR_WIDTH-1:0] dut__tb__sram_result_write_address,
    output logic [DATA_WIDTH-1:0] dut__tb__sram_result_write_data
);

`ifdef RESULT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int TOT_W = 2 * DIM_WIDTH;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    e_wb_state             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [TOT_W-1:0]      total_q, total_d;
    logic [TOT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [TOT_W-1:0]      push_cnt_q, push_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef RESULT_HEADER_EN
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
`endif

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [FCNT_W-1:0]     fifo_cnt;
    logic [FCNT_W-1:0]     fifo_cnt_next;

    assign fifo_push = res_valid && ready_q && !fifo_full;

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (res_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        total_d    = total_q;
        wr_cnt_d   = wr_cnt_q;
        push_cnt_d = push_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        fifo_pop   = 1'b0;
`ifdef RESULT_HEADER_EN
        rows_d     = rows_q;
        cols_d     = cols_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    total_d    = TOT_W'(rows) * TOT_W'(cols);
                    wr_cnt_d   = '0;
                    push_cnt_d = '0;
                    busy_d     = 1'b1;
`ifdef RESULT_HEADER_EN
                    rows_d     = rows;
                    cols_d     = cols;
                    state_d    = HEADER;
`else
                    state_d    = (total_d == '0) ? DONE : WRITE;
`endif
                end
            end
`ifdef RESULT_HEADER_EN
            HEADER: begin
                we_d    = 1'b1;
                waddr_d = base_q;
                wdata_d = DATA_WIDTH'(pack_dim_header(rows_q, cols_q));
                state_d = (total_q == '0) ? DONE : WRITE;
            end
`endif
            WRITE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                    waddr_d  = base_q + ADDR_WIDTH'(HDR) + wr_cnt_q[ADDR_WIDTH-1:0];
                    wdata_d  = fifo_rdata;
                    wr_cnt_d = wr_cnt_q + TOT_W'(1);
                    if (wr_cnt_q == total_q - TOT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fifo_push) push_cnt_d = push_cnt_q + TOT_W'(1);

        // Ready is registered, so it is derived from the occupancy after this
        // edge; a pop in the following cycle cannot re-open a full buffer.
        fifo_cnt_next = fifo_cnt + FCNT_W'(fifo_push) - FCNT_W'(fifo_pop);
        ready_d = (state_d == WRITE) && (fifo_cnt_next != FCNT_W'(FIFO_DEPTH))
                  && (push_cnt_d < total_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            push_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            push_cnt_q <= push_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Job parameters are only consulted after a start has loaded them.
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        total_q <= total_d;
`ifdef RESULT_HEADER_EN
        rows_q  <= rows_d;
        cols_q  <= cols_d;
`endif
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_ready = ready_q;
    assign dut__tb__sram_result_write_enable  = we_q;
    assign dut__tb__sram_result_write_address = waddr_q;
    assign dut__tb__sram_result_write_data    = wdata_q;

endmodule
